// File: rtl/seg_scan_if.sv
// Bundle of the seg_scan load-side inputs and display-side outputs.
// The slave modport is the display block; the master modport is whoever feeds it.
interface seg_scan_if;
   logic [15:0] data;
   logic [3:0]  dp_en;
   logic [3:0]  dig_en;
   logic        en;
   logic        load;
   logic [7:0]  SEG;
   logic [3:0]  AN;
   logic        frame_done;

   modport master (
      output data, dp_en, dig_en, en, load,
      input  SEG, AN, frame_done
   );

   modport slave (
      input  data, dp_en, dig_en, en, load,
      output SEG, AN, frame_done
   );
endinterface

// File: rtl/seg_scan.sv
// Four-digit multiplexed 7-segment scanner with per-slot blanking.
// New display contents are double-buffered so they only take effect on frame boundaries.
module seg_scan #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 1000
) (
   input logic       clk,
   input logic       rst,
   seg_scan_if.slave bus
);

   localparam int            CW      = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] BLANK   = CW'(BLANK_CYC);

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  dp_en;
      logic [3:0]  dig_en;
      logic        en;
   } disp_t;

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic          pflag;
   logic          fd_q;
   disp_t         pend;
   disp_t         shadow;
   disp_t         in_val;
   logic          wrap;
   logic          boundary;
   logic          drive;
   logic [3:0]    an_n;
   logic [7:0]    seg_n;

   function automatic logic [6:0] dec(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_comb begin
      in_val.data   = bus.data;
      in_val.dp_en  = bus.dp_en;
      in_val.dig_en = bus.dig_en;
      in_val.en     = bus.en;
   end

   assign wrap     = (cnt == CNT_MAX);
   assign boundary = wrap && (idx == 2'd3);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         idx    <= '0;
         pflag  <= 1'b0;
         fd_q   <= 1'b0;
         pend   <= '0;
         shadow <= '0;
      end else begin
         cnt  <= wrap ? '0 : cnt + CW'(1);
         fd_q <= boundary;
         if (wrap) idx <= idx + 2'd1;
         // A load landing on the boundary bypasses pending and wins over it.
         if (boundary) begin
            pflag <= 1'b0;
            if (bus.load)   shadow <= in_val;
            else if (pflag) shadow <= pend;
         end else if (bus.load) begin
            pend  <= in_val;
            pflag <= 1'b1;
         end
      end
   end

   // Outputs are decoded from registers only; blank phase leads each slot.
   assign drive = (cnt >= BLANK) && shadow.en && shadow.dig_en[idx];

   always_comb begin
      an_n  = 4'b0000;
      seg_n = 8'h00;
      if (drive) begin
         an_n  = 4'b0001 << idx;
         seg_n = {shadow.dp_en[idx], dec(shadow.data[{idx, 2'b00} +: 4])};
      end
   end

   assign bus.AN         = an_n;
   assign bus.SEG        = seg_n;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with SCAN_DIV=8, BLANK_CYC=2 (32-cycle frames).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_seg_scan;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc;
   int   nvec;
   int   nerr;

   always #5 clk = ~clk;

   seg_scan_if bus ();

   seg_scan #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic drive_load(input logic [15:0] d, input logic [3:0] dp,
                             input logic [3:0] dg, input logic e);
      bus.data   = d;
      bus.dp_en  = dp;
      bus.dig_en = dg;
      bus.en     = e;
      bus.load   = 1'b1;
   endtask

   task automatic tick;
      @(negedge clk);
      bus.load = 1'b0;
      cyc++;
   endtask

   task automatic test_reset;
      drive_load(16'hFFFF, 4'hF, 4'hF, 1'b1);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         nvec++;
         if ({bus.AN, bus.SEG, bus.frame_done} !== 13'h0) begin
            nerr++;
            $display("FAIL reset i=%0d got AN=%b SEG=%h fd=%b want AN=0000 SEG=00 fd=0",
                     i, bus.AN, bus.SEG, bus.frame_done);
         end
      end
      bus.load = 1'b0;
      rst      = 1'b0;
      cyc      = 0;
   endtask

   task automatic test_idle;
      logic ef;
      for (int i = 0; i < 64; i++) begin
         ef = (cyc % 32 == 0) && (cyc != 0);
         nvec++;
         if ({bus.AN, bus.SEG, bus.frame_done} !== {4'b0, 8'h00, ef}) begin
            nerr++;
            $display("FAIL idle cyc=%0d got AN=%b SEG=%h fd=%b want AN=0000 SEG=00 fd=%b",
                     cyc, bus.AN, bus.SEG, bus.frame_done, ef);
         end
         tick();
      end
   endtask

   task automatic test_load;
      logic [7:0] segs [4] = '{8'hE6, 8'h4F, 8'h5B, 8'h06};
      int p, s, c;
      logic on;
      logic [3:0] ea;
      logic [7:0] es;
      for (int i = 0; i < 64; i++) begin
         if (cyc == 64) drive_load(16'h1234, 4'b0001, 4'b1111, 1'b1);
         p  = cyc % 32; s = p / 8; c = p % 8;
         on = (cyc >= 96) && (c >= 2);
         ea = on ? 4'(1 << s) : 4'b0;
         es = on ? segs[s] : 8'h00;
         nvec++;
         if ({bus.AN, bus.SEG, bus.frame_done} !== {ea, es, p == 0}) begin
            nerr++;
            $display("FAIL load cyc=%0d got AN=%b SEG=%h fd=%b want AN=%b SEG=%h fd=%b",
                     cyc, bus.AN, bus.SEG, bus.frame_done, ea, es, p == 0);
         end
         tick();
      end
   endtask

   task automatic test_last_wins;
      logic [7:0] old_s [4] = '{8'hE6, 8'h4F, 8'h5B, 8'h06};
      logic [7:0] new_s [4] = '{8'hFF, 8'h07, 8'h7D, 8'h6D};
      int p, s, c;
      logic on;
      logic [3:0] ea;
      logic [7:0] es;
      for (int i = 0; i < 64; i++) begin
         if (cyc == 133) drive_load(16'hABCD, 4'b0001, 4'b1111, 1'b1);
         if (cyc == 140) drive_load(16'h5678, 4'b0001, 4'b1111, 1'b1);
         p  = cyc % 32; s = p / 8; c = p % 8;
         on = (c >= 2);
         ea = on ? 4'(1 << s) : 4'b0;
         es = on ? ((cyc < 160) ? old_s[s] : new_s[s]) : 8'h00;
         nvec++;
         if ({bus.AN, bus.SEG, bus.frame_done} !== {ea, es, p == 0}) begin
            nerr++;
            $display("FAIL last_wins cyc=%0d got AN=%b SEG=%h fd=%b want AN=%b SEG=%h fd=%b",
                     cyc, bus.AN, bus.SEG, bus.frame_done, ea, es, p == 0);
         end
         tick();
      end
   endtask

   task automatic test_boundary_load;
      logic [7:0] old_s [4] = '{8'hFF, 8'h07, 8'h7D, 8'h6D};
      int p, s, c;
      logic on;
      logic [3:0] ea;
      logic [7:0] es;
      for (int i = 0; i < 64; i++) begin
         if (cyc == 200) drive_load(16'h0000, 4'b1111, 4'b1111, 1'b1);
         if (cyc == 223) drive_load(16'hFFFF, 4'b0000, 4'b0101, 1'b1);
         p  = cyc % 32; s = p / 8; c = p % 8;
         if (cyc < 224) on = (c >= 2);
         else           on = (c >= 2) && (s == 0 || s == 2);
         ea = on ? 4'(1 << s) : 4'b0;
         es = on ? ((cyc < 224) ? old_s[s] : 8'h71) : 8'h00;
         nvec++;
         if ({bus.AN, bus.SEG, bus.frame_done} !== {ea, es, p == 0}) begin
            nerr++;
            $display("FAIL boundary_load cyc=%0d got AN=%b SEG=%h fd=%b want AN=%b SEG=%h fd=%b",
                     cyc, bus.AN, bus.SEG, bus.frame_done, ea, es, p == 0);
         end
         tick();
      end
   endtask

   task automatic test_disable;
      int p, s, c;
      logic on;
      logic [3:0] ea;
      logic [7:0] es;
      for (int i = 0; i < 64; i++) begin
         if (cyc == 260) drive_load(16'h1234, 4'b0001, 4'b1111, 1'b0);
         p  = cyc % 32; s = p / 8; c = p % 8;
         on = (cyc < 288) && (c >= 2) && (s == 0 || s == 2);
         ea = on ? 4'(1 << s) : 4'b0;
         es = on ? 8'h71 : 8'h00;
         nvec++;
         if ({bus.AN, bus.SEG, bus.frame_done} !== {ea, es, p == 0}) begin
            nerr++;
            $display("FAIL disable cyc=%0d got AN=%b SEG=%h fd=%b want AN=%b SEG=%h fd=%b",
                     cyc, bus.AN, bus.SEG, bus.frame_done, ea, es, p == 0);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] segs [4] = '{8'hE6, 8'h4F, 8'h5B, 8'h06};
      int p, s, c;
      logic on;
      logic ef;
      logic [3:0] ea;
      logic [7:0] es;
      while (cyc <= 405) begin
         if (cyc == 320) drive_load(16'h1234, 4'b0001, 4'b1111, 1'b1);
         if (cyc == 385) drive_load(16'h5678, 4'b0001, 4'b1111, 1'b1);
         p  = cyc % 32; s = p / 8; c = p % 8;
         on = (cyc >= 352) && (c >= 2);
         ea = on ? 4'(1 << s) : 4'b0;
         es = on ? segs[s] : 8'h00;
         nvec++;
         if ({bus.AN, bus.SEG, bus.frame_done} !== {ea, es, p == 0}) begin
            nerr++;
            $display("FAIL pre_reset cyc=%0d got AN=%b SEG=%h fd=%b want AN=%b SEG=%h fd=%b",
                     cyc, bus.AN, bus.SEG, bus.frame_done, ea, es, p == 0);
         end
         if (cyc == 405) rst = 1'b1;
         tick();
      end
      nvec++;
      if ({bus.AN, bus.SEG, bus.frame_done} !== 13'h0) begin
         nerr++;
         $display("FAIL in_reset got AN=%b SEG=%h fd=%b want AN=0000 SEG=00 fd=0",
                  bus.AN, bus.SEG, bus.frame_done);
      end
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 64; i++) begin
         ef = (cyc == 32);
         nvec++;
         if ({bus.AN, bus.SEG, bus.frame_done} !== {4'b0, 8'h00, ef}) begin
            nerr++;
            $display("FAIL post_reset rel=%0d got AN=%b SEG=%h fd=%b want AN=0000 SEG=00 fd=%b",
                     cyc, bus.AN, bus.SEG, bus.frame_done, ef);
         end
         tick();
      end
   endtask

   initial begin
      nvec       = 0;
      nerr       = 0;
      cyc        = 0;
      bus.data   = '0;
      bus.dp_en  = '0;
      bus.dig_en = '0;
      bus.en     = 1'b0;
      bus.load   = 1'b0;
      test_reset();
      test_idle();
      test_load();
      test_last_wins();
      test_boundary_load();
      test_disable();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, giving the clock cycles per digit slot (legal range >= 2).
REQ-002 The block SHALL have parameter BLANK_CYC, default 1000, giving the blanking cycles at the start of each slot (legal range 0 to SCAN_DIV-1).
REQ-003 The block SHALL have port clk, input, width 1: sole clock, rising edge.
REQ-004 The block SHALL have port rst, input, width 1: synchronous reset, active-high.
REQ-005 The block SHALL have port data, input, width 16: four hex digits, where digit i is data[4i+3:4i].
REQ-006 The block SHALL have port dp_en, input, width 4: decimal point on for digit i.
REQ-007 The block SHALL have port dig_en, input, width 4: digit i enabled.
REQ-008 The block SHALL have port en, input, width 1: global display enable.
REQ-009 The block SHALL have port load, input, width 1: one-cycle strobe that captures data, dp_en, dig_en and en.
REQ-010 The block SHALL have port SEG, output, width 8: SEG[7] is the decimal point and SEG[6:0] is segments g..a (bit0 = a); 1 means lit.
REQ-011 The block SHALL have port AN, output, width 4: one-hot digit select; 1 means digit active.
REQ-012 The block SHALL have port frame_done, output, width 1: one-cycle pulse at the end of each 4-digit frame.
REQ-013 The block SHALL use one clock, with synchronous, active-high reset rst.

Function
REQ-014 The block SHALL hold internal registers: slot counter cnt (0..SCAN_DIV-1), digit index idx (0..3), pending register set plus a pending flag, and shadow register set.
REQ-015 Each non-reset cycle, cnt SHALL increment; when cnt==SCAN_DIV-1, cnt SHALL become 0 and idx SHALL become (idx+1) mod 4.
REQ-016 The frame boundary cycle SHALL be the cycle in which cnt==SCAN_DIV-1 and idx==3; frame_done SHALL be 1 exactly in the cycle after it (cnt==0, idx==0) and 0 otherwise.
REQ-017 A load in a non-boundary cycle SHALL write the inputs into the pending registers and set the pending flag; a later load before the boundary SHALL overwrite them (last wins).
REQ-018 At the frame boundary, a set pending flag SHALL transfer pending to shadow and clear the flag; a load in the boundary cycle itself SHALL write the inputs directly into shadow, and pending SHALL be discarded.
REQ-019 Shadow values SHALL change only at frame boundaries, so no frame ever mixes old and new values (no tearing).
REQ-020 While cnt < BLANK_CYC (blank phase), AN SHALL be 0000 and SEG SHALL be 0x00.
REQ-021 While cnt >= BLANK_CYC (drive phase), if shadow en==1 and shadow dig_en[idx]==1, AN SHALL be one-hot(idx) and SEG SHALL be {shadow dp_en[idx], dec(shadow nibble idx)}; otherwise AN=0000 and SEG=0x00.
REQ-022 dec SHALL map 0-F to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
REQ-023 AN, SEG and frame_done SHALL depend on internal registers only, with no combinational path from any input.
REQ-024 When BLANK_CYC==0, the blank phase SHALL be absent and every slot SHALL drive for its full SCAN_DIV cycles.

Reset
REQ-025 While rst==1, the block SHALL set cnt=0, idx=0, pending flag=0, and all pending and shadow registers to 0.
REQ-026 While rst==1, the block SHALL drive AN=0000, SEG=0x00 and frame_done=0; a load asserted during reset SHALL be ignored.
REQ-027 Reset asserted mid-frame SHALL abandon the current frame and discard any pending load; after release, scanning SHALL restart at idx 0, cnt 0, with the display blank until the first load reaches a frame boundary.

Verification
REQ-028 The bench SHALL run its scenarios with SCAN_DIV=8 and BLANK_CYC=2.
REQ-029 Scenario: reset released, no load for 64 cycles -> AN=0000 and SEG=00 throughout; frame_done pulses every 32 cycles, first at cycle 32 after release.
REQ-030 Scenario: load data=0x1234, dp_en=0001, dig_en=1111, en=1 -> from the next frame, per slot: cycles 0-1 blank, cycles 2-7 AN=0001/SEG=E6 (digit 4 with DP), then AN=0010/SEG=4F, AN=0100/SEG=5B, AN=1000/SEG=06.
REQ-031 Scenario: load 0xABCD mid-frame, then load 0x5678 in the same frame -> the current frame stays 0x1234; the next frame shows 0x5678; 0xABCD is never displayed.
REQ-032 Scenario: load in the boundary cycle with data=0xFFFF, dig_en=0101 -> the next frame shows SEG=71 on digits 0 and 2; slots 1 and 3 give AN=0000/SEG=00.
REQ-033 Scenario: en=0 loaded -> AN=0000 and SEG=00 for every slot from the next frame; frame_done keeps pulsing every 32 cycles.
REQ-034 Scenario: rst pulsed at idx=2, cnt=5 with a pending load outstanding -> outputs 0 in the next cycle; after release, frame_done occurs 32 cycles later and the display stays blank.
